// File: rtl/oddr_serializer.sv
// Output gearbox: wide beats in over valid/ready, two WIDTH-bit symbols per clock out
// on d1/d2 for a DDR output flop, with a one-beat hold buffer, frame tracking and underflow count.
module oddr_serializer #(
    parameter int                   WIDTH      = 1,
    parameter int                   RATIO      = 8,
    parameter logic [WIDTH-1:0]     IDLE_VALUE = '0,
    parameter int                   CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH*RATIO-1:0]  s_data,
    input  logic                    s_last,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [WIDTH-1:0]        d1,
    output logic [WIDTH-1:0]        d2,
    output logic                    q_active,
    output logic [CNT_WIDTH-1:0]    underflow_cnt,
    input  logic                    underflow_clr
);

    localparam int PAIRS = RATIO / 2;
    localparam int CNTW  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CNTW-1:0] LAST_PAIR = CNTW'(PAIRS - 1);

    if ((RATIO % 2) != 0 || RATIO < 2 || RATIO > 16) begin : g_bad_ratio
        $error("oddr_serializer: RATIO must be even and within 2..16");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("oddr_serializer: WIDTH must be within 1..64");
    end

    logic [WIDTH*RATIO-1:0] hold_data_q, hold_data_d;
    logic                   hold_last_q, hold_last_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [WIDTH*RATIO-1:0] sh_data_q, sh_data_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic                   sh_valid_q, sh_valid_d;
    logic                   in_frame_q, in_frame_d;
    logic [CNT_WIDTH-1:0]   ucnt_q, ucnt_d;

    logic last_pair, load, accept, uf_event;

    assign last_pair = sh_valid_q && (cnt_q == LAST_PAIR);
    assign load      = hold_valid_q && (!sh_valid_q || cnt_q == LAST_PAIR);
    assign s_ready   = rst_n && (!hold_valid_q || load);
    assign accept    = s_valid && s_ready;
    // Starved mid-frame: the shifter drains with nothing behind it and no s_last seen yet.
    assign uf_event  = last_pair && in_frame_q && !hold_valid_q;

    always_comb begin
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        hold_valid_d = hold_valid_q;
        sh_data_d    = sh_data_q;
        cnt_d        = cnt_q;
        sh_valid_d   = sh_valid_q;
        in_frame_d   = in_frame_q;
        ucnt_d       = ucnt_q;

        if (load) begin
            sh_data_d    = hold_data_q;
            cnt_d        = '0;
            sh_valid_d   = 1'b1;
            hold_valid_d = 1'b0;
            in_frame_d   = !hold_last_q;
        end else if (sh_valid_q) begin
            if (cnt_q == LAST_PAIR) sh_valid_d = 1'b0;
            else                    cnt_d      = cnt_q + 1'b1;
        end

        if (accept) begin
            hold_data_d  = s_data;
            hold_last_d  = s_last;
            hold_valid_d = 1'b1;
        end

        if (underflow_clr)               ucnt_d = '0;
        else if (uf_event && !(&ucnt_q)) ucnt_d = ucnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            sh_data_q    <= '0;
            cnt_q        <= '0;
            sh_valid_q   <= 1'b0;
            in_frame_q   <= 1'b0;
            ucnt_q       <= '0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            hold_valid_q <= hold_valid_d;
            sh_data_q    <= sh_data_d;
            cnt_q        <= cnt_d;
            sh_valid_q   <= sh_valid_d;
            in_frame_q   <= in_frame_d;
            ucnt_q       <= ucnt_d;
        end
    end

    always_comb begin
        d1       = IDLE_VALUE;
        d2       = IDLE_VALUE;
        q_active = sh_valid_q;
        if (sh_valid_q) begin
            for (int p = 0; p < PAIRS; p++) begin
                if (cnt_q == CNTW'(p)) begin
                    d1 = sh_data_q[(2*p)*WIDTH +: WIDTH];
                    d2 = sh_data_q[(2*p+1)*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_oddr_serializer.sv
// Self-checking bench for oddr_serializer (WIDTH=4, RATIO=4, CNT_WIDTH=2) against a
// queue-based transaction model: accepted beats become symbol pairs consumed one per cycle.
module tb_oddr_serializer;
    localparam int W = 4;
    localparam int R = 4;
    localparam int PAIRS = R / 2;
    localparam int CW = 2;
    localparam int UMAX = 3;
    localparam logic [W-1:0] IDLE = 4'hE;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [W*R-1:0]  s_data = '0;
    logic            s_last = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [W-1:0]    d1, d2;
    logic            q_active;
    logic [CW-1:0]   underflow_cnt;
    logic            underflow_clr = 1'b0;

    oddr_serializer #(.WIDTH(W), .RATIO(R), .IDLE_VALUE(IDLE), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
        .s_ready(s_ready), .d1(d1), .d2(d2), .q_active(q_active),
        .underflow_cnt(underflow_cnt), .underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model state: one-beat hold slot plus a queue of pending {d2,d1} pairs.
    logic [W*R-1:0] h_data;
    logic           h_last;
    logic           h_full = 1'b0;
    logic [2*W-1:0] outq[$];
    logic           in_fr = 1'b0;
    int             ucnt = 0;
    logic           m_ready, m_acc;
    int             run = 0, max_run = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input logic v, input logic [W*R-1:0] dat, input logic lst,
                        input logic clr, input logic rst);
        logic ld, ev, lp;
        @(negedge clk);
        chk("q_active", q_active, outq.size() > 0);
        chk("d1", d1, (outq.size() > 0) ? outq[0][W-1:0] : IDLE);
        chk("d2", d2, (outq.size() > 0) ? outq[0][2*W-1:W] : IDLE);
        chk("ucnt", underflow_cnt, ucnt);
        run = q_active ? run + 1 : 0;
        if (run > max_run) max_run = run;
        rst_n = rst; s_valid = v; s_data = dat; s_last = lst; underflow_clr = clr;
        m_ready = rst && (!h_full || outq.size() <= 1);
        #1 chk("s_ready", s_ready, m_ready);
        @(posedge clk);
        m_acc = v && m_ready;
        if (!rst) begin
            h_full = 1'b0; outq.delete(); in_fr = 1'b0; ucnt = 0; m_acc = 1'b0;
        end else begin
            lp = (outq.size() == 1);
            ld = h_full && outq.size() <= 1;
            ev = lp && in_fr && !h_full;
            if (outq.size() > 0) void'(outq.pop_front());
            if (ld) begin
                for (int p = 0; p < PAIRS; p++)
                    outq.push_back({h_data[(2*p+1)*W +: W], h_data[(2*p)*W +: W]});
                in_fr = !h_last;
                h_full = 1'b0;
            end
            if (m_acc) begin
                h_data = dat; h_last = lst; h_full = 1'b1;
            end
            if (clr) ucnt = 0;
            else if (ev && ucnt < UMAX) ucnt++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    // Offer a beat until accepted, bounded.
    task automatic send(input logic [W*R-1:0] dat, input logic lst);
        int tries = 0;
        do begin
            step(1'b1, dat, lst, 1'b0, 1'b1);
            tries++;
        end while (!m_acc && tries < 8);
        if (!m_acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d1", d1, IDLE);
        chk("rst_qa", q_active, 0);
        chk("rst_ucnt", underflow_cnt, 0);
        chk("rst_ready", s_ready, 0);

        // Single beat: 2-cycle latency, symbol 0 first.
        step(1'b1, 16'hDCBA, 1'b1, 1'b0, 1'b1);
        idle(1); #1;
        chk("sb_d1a", d1, 4'hA); chk("sb_d2b", d2, 4'hB); chk("sb_qa", q_active, 1);
        idle(1); #1;
        chk("sb_d1c", d1, 4'hC); chk("sb_d2d", d2, 4'hD);
        idle(1); #1;
        chk("sb_idle", d1, IDLE); chk("sb_qa0", q_active, 0); chk("sb_ucnt", underflow_cnt, 0);
        idle(2);

        // Streaming: 10 beats gapless.
        max_run = 0;
        for (int i = 0; i < 10; i++) send(16'($urandom), i == 9);
        idle(5);
        chk("stream_run", max_run, 10 * PAIRS);

        // Backpressure: 3 beats offered continuously.
        max_run = 0;
        for (int i = 0; i < 3; i++) send(16'($urandom), i == 2);
        idle(5);
        chk("bp_run", max_run, 3 * PAIRS);
        chk("bp_ucnt", underflow_cnt, 0);

        // Underflow mid-frame, then a closing beat and extra idle.
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        idle(5); #1;
        chk("uf_cnt1", underflow_cnt, 1);
        chk("uf_gap", q_active, 0);
        send(16'h5678, 1'b1);
        idle(8); #1;
        chk("uf_hold1", underflow_cnt, 1);

        // Saturation and clear-priority.
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b1);
            idle(3);
        end
        #1 chk("sat3", underflow_cnt, 3);
        step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        #1 chk("clr_pri", underflow_cnt, 0);
        send(16'h9999, 1'b1);
        idle(5);

        // Reset while cnt=1.
        step(1'b1, 16'hFEDC, 1'b1, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
        #1 chk("mr_qa", q_active, 0); chk("mr_d1", d1, IDLE);
        idle(1); #1 chk("mr_noresume", q_active, 0);
        step(1'b1, 16'h4321, 1'b1, 1'b0, 1'b1);
        idle(1); #1;
        chk("mr_d1", d1, 4'h1); chk("mr_d2", d2, 4'h2);
        idle(3);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 63) != 0);
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
